// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared CPU definitions for the HI/LO multiply-divide unit
//               (op encodings, move-to encodings, default latencies).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } md_op_e;

    localparam logic [1:0] c_hilo_none = 2'b00;
    localparam logic [1:0] c_hilo_mtlo = 2'b01;
    localparam logic [1:0] c_hilo_mthi = 2'b10;

    localparam int c_mult_cycles = 5;
    localparam int c_div_cycles  = 10;

    // Encodings 5-7 are reserved and behave like MD_NONE.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit with move-to-HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles,
    parameter int DIV_CYCLES  = c_div_cycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  start,
    input  logic [1:0]  hilo_we,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic        w_start_ok;
    logic        w_last;
    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_valid;

    assign w_start_ok = (r_state == S_IDLE) && is_md_op(start);
    assign w_last     = (r_state == S_BUSY) && (r_count == c_one);
    assign w_signed   = (r_op == MD_MULT) || (r_op == MD_DIV);
    assign w_is_div   = (r_op == MD_DIV) || (r_op == MD_DIVU);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both flavours.
    assign w_prod = {{32{w_signed & r_a[31]}}, r_a} * {{32{w_signed & r_b[31]}}, r_b};

    // Signed divide via magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0.
    assign w_a_neg = w_signed & r_a[31];
    assign w_b_neg = w_signed & r_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);

    always_comb begin
        w_res_valid = 1'b1;
        w_res_hi    = w_prod[63:32];
        w_res_lo    = w_prod[31:0];
        if (w_is_div) begin
            w_res_valid = (r_b != 32'd0);
            w_res_lo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
            w_res_hi    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_next = S_BUSY;
            S_BUSY:  if (w_last)     w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_BUSY);
    end

    assign md_out = hilo_sel ? r_hi : r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_start_ok) begin
                r_op    <= start;
                r_a     <= A;
                r_b     <= B;
                r_count <= ((start == MD_MULT) || (start == MD_MULTU)) ?
                           c_cnt_w'(MULT_CYCLES) : c_cnt_w'(DIV_CYCLES);
            end else if (hilo_we == c_hilo_mtlo) begin
                r_lo <= A;
            end else if (hilo_we == c_hilo_mthi) begin
                r_hi <= A;
            end
        end else begin
            r_count <= r_count - c_one;
            if (w_last && w_res_valid) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit with arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [2:0]  start = 3'd0;
    logic [1:0]  hilo_we = 2'b00;
    logic        hilo_sel = 1'b0;
    logic        busy;
    logic [31:0] md_out;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .A        (a),
        .B        (b),
        .start    (start),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .busy     (busy),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hilo_sel = 1'b1; #1; hi = md_out;
        hilo_sel = 1'b0; #1; lo = md_out;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi, lo;
        read_hilo(hi, lo);
        check({tag, ".hi"}, hi, ehi);
        check({tag, ".lo"}, lo, elo);
    endtask

    // Reference: plain 64-bit arithmetic on the operands as the ISA defines them.
    task automatic model_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, q, r;
        logic [63:0] p;
        case (op)
            3'd1: begin
                sx = longint'($signed(x)); sy = longint'($signed(y));
                p = 64'(sx * sy);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd3, 3'd4: begin
                if (y != 32'd0) begin
                    if (op == 3'd3) begin
                        sx = longint'($signed(x)); sy = longint'($signed(y));
                    end else begin
                        sx = longint'({32'd0, x}); sy = longint'({32'd0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd2) ? 5 : 10;
    endfunction

    // Issue one op at a negedge; optionally disturb inputs while busy.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [1:0] we, input bit disturb);
        int cycles;
        @(negedge clk);
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
        a = x; b = y; start = op; hilo_we = we;
        @(negedge clk);
        start = 3'd0; hilo_we = 2'b00;
        model_op(op, x, y);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (disturb) begin
                a = $urandom; b = $urandom; start = 3'd3; hilo_we = 2'b01;
            end
            @(negedge clk);
        end
        start = 3'd0; hilo_we = 2'b00;
        check({tag, ".cycles"}, 32'(cycles), 32'(latency(op)));
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic [2:0]  op;
        logic [31:0] x, y;
        int          cyc;

        #2;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 2'b00, 1'b0);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 2'b00, 1'b0);
        check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op("div", 3'd3, -32'sd7, 32'd2, 2'b00, 1'b0);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divu", 3'd4, 32'd7, 32'd2, 2'b00, 1'b0);
        check_hilo("divu", 32'd1, 32'd3);

        @(negedge clk);
        a = 32'h1234; hilo_we = 2'b10;
        @(negedge clk);
        hilo_we = 2'b00; m_hi = 32'h1234;
        check_hilo("mthi", 32'h1234, 32'd3);

        run_op("div0", 3'd3, 32'd99, 32'd0, 2'b00, 1'b0);
        check_hilo("div0", 32'h1234, 32'd3);

        run_op("ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0);
        check_hilo("ovf", 32'd0, 32'h8000_0000);

        run_op("ignore", 3'd4, 32'd100, 32'd7, 2'b00, 1'b1);
        check_hilo("ignore", 32'd2, 32'd14);

        run_op("prio", 3'd1, 32'd3, 32'd4, 2'b10, 1'b0);
        check_hilo("prio", 32'd0, 32'd12);

        // Abort a divide at its fourth busy cycle.
        @(negedge clk);
        a = 32'd50; b = 32'd3; start = 3'd3;
        @(negedge clk);
        start = 3'd0;
        repeat (3) @(negedge clk);
        check("abort.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0; #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check_hilo("abort", 32'd0, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        a = 32'd6; b = 32'd7; start = 3'd1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        start = 3'd0;
        check("post_reset.busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (busy && cyc < 100) begin
            @(posedge clk); #1;
            if (busy) cyc++;
        end
        check("post_reset.cycles", 32'(cyc), 32'd5);
        check_hilo("post_reset", 32'd0, 32'd42);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 4));
            x  = $urandom;
            y  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                a = $urandom; hilo_we = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
                if (hilo_we == 2'b01) m_lo = a; else m_hi = a;
                @(negedge clk);
                hilo_we = 2'b00;
            end
            run_op("rand", op, x, y, 2'b00, 1'b0);
            read_hilo(hi, lo);
            check("rand.hi", hi, m_hi);
            check("rand.lo", lo, m_lo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
